// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the data-memory responder of the single-cycle
// MIPS core: MMIO register offsets (relative to the MMIO window base), STATUS
// word bit positions and the address-region decode type.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Byte offsets inside the MMIO window (addr[15:0]).
    localparam logic [15:0] OFF_CYCLES = 16'h0000;
    localparam logic [15:0] OFF_TXDATA = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;

    // STATUS word layout.
    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_MISALIGN = 3;
    localparam int ST_CNT_LO   = 8;
    localparam int ST_CNT_HI   = 15;

    // Which target an address selects.
    typedef enum logic {
        REG_RAM  = 1'b0,
        REG_MMIO = 1'b1
    } region_e;

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Bundles the core data port and the output-stream handshake of the
// data-memory responder.
//   memwrite/addr/writedata : core store strobe, byte address, store data
//   readdata                : load data, combinational from addr
//   out_data/out_valid      : output FIFO head word and non-empty flag
//   out_ready               : consumer accepts the head when out_valid=1
//   err_misaligned          : sticky misaligned-access flag
// Modports: master = core + consumer side, slave = responder.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    import dmem_pkg::*;

    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_misaligned;

    modport master (
        output memwrite, addr, writedata, out_ready,
        input  readdata, out_data, out_valid, err_misaligned
    );

    modport slave (
        input  memwrite, addr, writedata, out_ready,
        output readdata, out_data, out_valid, err_misaligned
    );

endinterface

// File: rtl/dmem_out_fifo.sv
// -----------------------------------------------------------------------------
// dmem_out_fifo
// Synchronous single-clock FIFO feeding the responder's output stream.
// Ports:
//   clk, reset     : clock, synchronous active-low reset (pointers/count only)
//   push, din      : write request and data
//   pop            : read request (ignored while empty)
//   dout           : head entry, 0 while empty
//   empty, full    : occupancy flags
//   count          : number of stored entries
//   push_accepted  : push taken this cycle (room, or a pop frees a slot)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module dmem_out_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              push_accepted
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_pop;
    logic              do_push;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop        = pop & ~empty;
    assign do_push       = push & (~full | do_pop);
    assign push_accepted = do_push;

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Zero-wait-state data-memory responder for the single-cycle MIPS core: a word
// RAM plus an MMIO window holding a free-running cycle counter, an output FIFO
// drained over valid/ready, and a status/control word.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous reset, active-low
//   bus   : dmem_responder_if.slave (core data port + output stream + error)
// Build option: define DMEM_MISALIGN_CHECK_EN to suppress and flag accesses
// with addr[1:0]!=0 (sticky err_misaligned, STATUS bit3). Without it the low
// address bits are ignored and err_misaligned stays 0.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    region_e           region;
    logic [ADDR_W-1:0] ram_idx;
    logic [13:0]       word_off;
    logic              misaligned;
    logic              wr_en;
    logic              mmio_wr;

    logic [31:0]       ram [2**ADDR_W];
    logic [31:0]       cycles_q;
    logic              ovf_q;
    logic              err_q;
    logic              cyc_clr;
    logic              ovf_clr;

    logic              push_req;
    logic              push_acc;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       fifo_dout;

    logic [31:0]       status_word;
    logic [31:0]       mmio_rdata;
    logic [31:0]       rdata;

    // Address decode. Offsets compare on word granularity so the byte lane
    // bits play no part in selecting a register.
    assign region   = (bus.addr[31:16] == MMIO_BASE[31:16]) ? REG_MMIO : REG_RAM;
    assign ram_idx  = bus.addr[ADDR_W+1:2];
    assign word_off = bus.addr[15:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = (bus.addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (misaligned) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_lsb;
    assign unused_lsb = ^bus.addr[1:0];
    assign misaligned = 1'b0;
    assign err_q      = 1'b0;
`endif

    // Writes are dropped while reset is asserted and when misaligned.
    assign wr_en   = bus.memwrite & reset & ~misaligned;
    assign mmio_wr = wr_en & (region == REG_MMIO);

    assign cyc_clr  = mmio_wr & (word_off == OFF_CYCLES[15:2]);
    assign push_req = mmio_wr & (word_off == OFF_TXDATA[15:2]);
    assign ovf_clr  = mmio_wr & (word_off == OFF_STATUS[15:2]) & bus.writedata[ST_OVF];

    // RAM: contents survive reset; reads are asynchronous so a same-cycle
    // write is only visible from the next cycle on.
    always_ff @(posedge clk) begin
        if (wr_en && region == REG_RAM) begin
            ram[ram_idx] <= bus.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles_q <= '0;
        end else if (cyc_clr) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    // A rejected push and a clear-write cannot share a cycle (different
    // offsets), so the ordering here never matters in practice.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (push_req && !push_acc) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign pop = bus.out_ready & ~fifo_empty;

    dmem_out_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32),
        .CNT_W  (CNT_W)
    ) u_out_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (push_req),
        .din           (bus.writedata),
        .pop           (pop),
        .dout          (fifo_dout),
        .empty         (fifo_empty),
        .full          (fifo_full),
        .count         (fifo_count),
        .push_accepted (push_acc)
    );

    assign bus.out_valid      = ~fifo_empty;
    assign bus.out_data       = fifo_dout;
    assign bus.err_misaligned = err_q;

    always_comb begin
        status_word                        = '0;
        status_word[ST_EMPTY]              = fifo_empty;
        status_word[ST_FULL]               = fifo_full;
        status_word[ST_OVF]                = ovf_q;
        status_word[ST_MISALIGN]           = err_q;
        status_word[ST_CNT_HI:ST_CNT_LO]   = 8'(fifo_count);
    end

    always_comb begin
        mmio_rdata = '0;
        case (word_off)
            OFF_CYCLES[15:2]: mmio_rdata = cycles_q;
            OFF_TXDATA[15:2]: mmio_rdata = fifo_dout;
            OFF_STATUS[15:2]: mmio_rdata = status_word;
            default:          mmio_rdata = '0;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (!misaligned) begin
            rdata = (region == REG_MMIO) ? mmio_rdata : ram[ram_idx];
        end
    end

    assign bus.readdata = rdata;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS core. Answers the core's data port (memwrite, aluout as address, writedata, readdata).
- Word RAM plus a small memory-mapped I/O window:
  - free-running cycle counter
  - output FIFO drained by an external consumer over a valid/ready handshake
  - status/control word
- Sits beside the core at top level. Core sees zero-wait-state memory.

Parameters:
ADDR_W, 10, RAM word-address width (2^ADDR_W 32-bit words)
FIFO_DEPTH, 8, output FIFO entries (power of two, 2..128)
MMIO_BASE, 32'hFFFF_0000, base of the MMIO window (upper 16 bits decoded)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous reset, active-low (0 = reset, sampled on rising edge of clk)
memwrite  in  1  core write strobe
addr  in  32  byte address (core aluout)
writedata  in  32  core store data
readdata  out  32  load data, combinational from addr
out_data  out  32  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid=1
err_misaligned  out  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Decode: MMIO when addr[31:16]==MMIO_BASE[31:16]; otherwise RAM. RAM index = addr[ADDR_W+1:2]; higher RAM address bits ignored (aliasing).
- RAM write: on rising edge when memwrite=1 and decode=RAM. RAM read: combinational, same cycle. Read-during-write returns the old word. RAM contents are not affected by reset.
- MMIO map (offset addr[15:0]):
  - 0x0000 CYCLES: RO counter. A write sets next value to 0; write data ignored.
  - 0x0004 TXDATA: a write pushes writedata. A read returns the head (peek, no pop), or 0 when empty.
  - 0x0008 STATUS:
    - bit0 empty
    - bit1 full
    - bit2 overflow (sticky)
    - bits[15:8] count
    - other bits 0
    - A write with writedata[2]=1 clears overflow. Other written bits are ignored.
  - Any other offset: reads return 0; writes ignored.
- Cycle counter: +1 every cycle, wraps 32'hFFFF_FFFF -> 0. Clear-by-write wins over increment.
- FIFO:
  - pop = out_valid & out_ready.
  - push request = memwrite at TXDATA.
  - Push is accepted if count<FIFO_DEPTH or pop occurs in the same cycle. Full plus simultaneous push and pop: accepted, count unchanged.
  - Rejected push sets overflow. The clear-write and a set of overflow in the same cycle cannot coincide, since they are different addresses.
  - No bypass: a push into an empty FIFO raises out_valid the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data = head entry when out_valid=1, else 32'h0.
  - out_data and out_valid are stable until pop.
- Reset (reset=0 at edge, including mid-transfer): counter=0, FIFO emptied (pointers and count 0), overflow=0, err_misaligned=0.
  - After reset: out_valid=0, out_data=0. STATUS reads 32'h0000_0001. CYCLES reads 0 in the first post-reset cycle.
  - readdata for RAM addresses reflects the retained RAM contents.
- Writes in the cycle reset is asserted are ignored.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- With the macro: any access with addr[1:0]!=0 is checked.
  - Write (memwrite=1): suppressed entirely, so there is no RAM update, no push, and no counter/overflow clear. err_misaligned sets the next cycle and stays 1 until reset.
  - Read: flags err_misaligned in the same way, and readdata=0.
  - STATUS bit3 mirrors err_misaligned.
- Without the macro: addr[1:0] is ignored, err_misaligned is tied 0, STATUS bit3 reads 0.

Decomposition:
- Package dmem_pkg:
  - MMIO offset constants: OFF_CYCLES, OFF_TXDATA, OFF_STATUS.
  - STATUS bit-position constants.
  - Region decode enum: REG_RAM, REG_MMIO.
- Sub-module dmem_out_fifo: parameterised sync FIFO.
  - Inputs: push, din, pop.
  - Outputs: dout, empty, full, count, push_accepted.
  - Owns pointer/wrap logic.
- Top module holds decode, RAM array, counter, overflow/err flags, readdata mux.

Test Plan:
- Reset then write 32'hDEADBEEF to 0x0000_0010 and read it back -> readdata 32'hDEADBEEF same cycle as read; 0x0000_0010+2^(ADDR_W+2) aliases to the same word.
- Hold reset 3 cycles, release, idle 5 cycles -> CYCLES reads 5; write CYCLES -> next cycle reads 0. Preload counter near wrap via long run or force -> 32'hFFFF_FFFF followed by 0.
- Push 1..8 with out_ready=0 -> full=1, count=8. 9th push -> dropped, overflow=1. Drain with out_ready=1 -> out_data 1..8 in order, then out_valid=0, STATUS=32'h0000_0005. Write STATUS with bit2 -> 32'h0000_0001.
- FIFO full, out_ready=1 and push 32'hA5 same cycle -> no overflow, count stays 8, 32'hA5 emerges last.
- Push 3 words, assert reset mid-drain -> next cycle out_valid=0, STATUS=32'h0000_0001, earlier RAM data still readable.
- DMEM_MISALIGN_CHECK_EN defined: write 32'h1234 to 0x0000_0022 -> RAM word 8 unchanged, err_misaligned=1 next cycle and held. Macro undefined: same write updates word 8, err_misaligned=0.
